// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared types and helpers for the PS/2 host-side blocks.
//   ps2_state_t : host transmitter state encoding
//   us_to_cyc   : microseconds -> clk cycles, evaluated at elaboration
//   odd_parity  : PS/2 parity bit for a data byte (odd parity over 9 bits)
// ----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      DATA,
      ACK,
      WAIT_IDLE,
      FIN
   } ps2_state_t;

   function automatic int us_to_cyc(input int clk_freq, input int us);
      return (clk_freq / 1_000_000) * us;
   endfunction

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Brings one raw open-collector PS/2 line into the clk domain and reports
// falling edges. Shared by the host transmitter and the PS/2 receivers.
//
// Build option: PS2_TX_GLITCH_FILTER_EN
//   defined   - the synchronized level only changes once 4 consecutive samples
//               agree, rejecting pulses of 3 clk or shorter (fall after 7 clk)
//   undefined - plain 2-FF synchronizer (fall after 3 clk)
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   i_line  in   raw asynchronous line
//   o_level out  synchronized (optionally filtered) line level
//   o_fall  out  one-cycle strobe when o_level goes 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       r_level_d;
   logic       r_fall;
   logic       w_level;

   // Idle bus level is high, so reset to 1 to avoid a false fall after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_line};
      end
   end

`ifdef PS2_TX_GLITCH_FILTER_EN
   logic [2:0] r_hist;
   logic       r_filt;
   logic [3:0] w_window;

   // The window is the three previous samples plus the current one.
   assign w_window = {r_hist, r_sync[1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist <= 3'b111;
         r_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[1:0], r_sync[1]};
         if (w_window == 4'h0) begin
            r_filt <= 1'b0;
         end else if (w_window == 4'hF) begin
            r_filt <= 1'b1;
         end
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync[1];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_level_d <= 1'b1;
         r_fall    <= 1'b0;
      end else begin
         r_level_d <= w_level;
         r_fall    <= r_level_d & ~w_level;
      end
   end

   assign o_level = w_level;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte to a mouse or
// keyboard. Lines are open-collector; this block only drives output enables.
//
// Build option: PS2_TX_GLITCH_FILTER_EN (clock-line glitch filter, see
// ps2_line_sync).
//
// Ports:
//   clk        in   system clock (wb_clk)
//   reset      in   synchronous, active-high reset
//   tx_data    in   byte to send, captured when tx_start is accepted
//   tx_start   in   one-cycle request, ignored while busy
//   busy       out  transfer in progress
//   done       out  one-cycle end-of-transfer pulse
//   error      out  with done: 1 = timeout or NACK; held until next start
//   ps2_clk_i  in   raw PS/2 clock line
//   ps2_dat_i  in   raw PS/2 data line
//   ps2_clk_oe out  1 = pull clock line low
//   ps2_dat_oe out  1 = pull data line low
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low; data pulled low in the final cycle (start bit)
// START     | clock released, waiting for first device fall (start timeout)
// DATA      | falls 2..9 shift data bits and parity, fall 10 releases data
// ACK       | fall 11 samples the device ack (0 = ack, 1 = NACK)
// WAIT_IDLE | wait for both lines high, bounded by the packet timer
// FIN       | done pulse
// ----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ          = 4000000,
   parameter int INHIBIT_US        = 120,
   parameter int START_TIMEOUT_US  = 15000,
   parameter int PACKET_TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int INHIBIT_CYC = us_to_cyc(CLK_FREQ, INHIBIT_US);
   localparam int START_CYC   = us_to_cyc(CLK_FREQ, START_TIMEOUT_US);
   localparam int PKT_CYC     = us_to_cyc(CLK_FREQ, PACKET_TIMEOUT_US);
   localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
   localparam int MAX_CYC     = (MAX_A > PKT_CYC) ? MAX_A : PKT_CYC;
   localparam int TW          = $clog2(MAX_CYC);

   localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] START_LOAD   = TW'(START_CYC - 1);
   localparam logic [TW-1:0] PKT_LOAD     = TW'(PKT_CYC - 1);

   ps2_state_t    r_state,   w_state_nxt;
   logic [TW-1:0] r_timer,   w_timer_nxt;
   logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [8:0]    r_shift,   w_shift_nxt;
   logic          r_busy,    w_busy_nxt;
   logic          r_done,    w_done_nxt;
   logic          r_error,   w_error_nxt;
   logic          r_clk_oe,  w_clk_oe_nxt;
   logic          r_dat_oe,  w_dat_oe_nxt;

   logic w_clk_level, w_clk_fall;
   logic w_dat_level, w_dat_fall_unused;
   logic w_timer_zero, w_timeout;

   ps2_line_sync u_clk_sync (
      .clk     (clk),
      .reset   (reset),
      .i_line  (ps2_clk_i),
      .o_level (w_clk_level),
      .o_fall  (w_clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clk     (clk),
      .reset   (reset),
      .i_line  (ps2_dat_i),
      .o_level (w_dat_level),
      .o_fall  (w_dat_fall_unused)
   );

   assign w_timer_zero = (r_timer == '0);
   assign w_timeout    = w_timer_zero &&
                         (r_state == START || r_state == DATA ||
                          r_state == ACK   || r_state == WAIT_IDLE);

   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_error_nxt   = r_error;
      w_clk_oe_nxt  = r_clk_oe;
      w_dat_oe_nxt  = r_dat_oe;

      case (r_state)
         // busy is already low during FIN, so a start there is accepted too.
         IDLE, FIN: begin
            w_state_nxt  = IDLE;
            w_busy_nxt   = 1'b0;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            if (tx_start) begin
               w_state_nxt  = INHIBIT;
               w_shift_nxt  = {odd_parity(tx_data), tx_data};
               w_busy_nxt   = 1'b1;
               w_error_nxt  = 1'b0;
               w_timer_nxt  = INHIBIT_LOAD;
               w_clk_oe_nxt = 1'b1;
            end
         end
         INHIBIT: begin
            w_timer_nxt = r_timer - TW'(1);
            // Registered outputs: look one cycle ahead so data drops in the
            // last inhibit cycle.
            if (r_timer == TW'(1)) begin
               w_dat_oe_nxt = 1'b1;
            end
            if (w_timer_zero) begin
               w_state_nxt   = START;
               w_clk_oe_nxt  = 1'b0;
               w_dat_oe_nxt  = 1'b1;
               w_bit_cnt_nxt = 4'd0;
               w_timer_nxt   = START_LOAD;
            end
         end
         START: begin
            w_timer_nxt = r_timer - TW'(1);
            if (w_clk_fall) begin
               w_dat_oe_nxt  = ~r_shift[0];
               w_shift_nxt   = r_shift >> 1;
               w_bit_cnt_nxt = 4'd1;
               w_timer_nxt   = PKT_LOAD;
               w_state_nxt   = DATA;
            end
         end
         DATA: begin
            w_timer_nxt = r_timer - TW'(1);
            if (w_clk_fall) begin
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd9) begin
                  w_dat_oe_nxt = 1'b0;
                  w_state_nxt  = ACK;
               end else begin
                  w_dat_oe_nxt = ~r_shift[0];
                  w_shift_nxt  = r_shift >> 1;
               end
            end
         end
         ACK: begin
            w_timer_nxt = r_timer - TW'(1);
            if (w_clk_fall) begin
               w_error_nxt = w_dat_level;
               w_state_nxt = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            w_timer_nxt = r_timer - TW'(1);
            if (w_clk_level && w_dat_level) begin
               w_state_nxt = FIN;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // A timeout overrides whatever the current state decided this cycle.
      if (w_timeout) begin
         w_state_nxt  = IDLE;
         w_clk_oe_nxt = 1'b0;
         w_dat_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_done_nxt   = 1'b1;
         w_error_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_bit_cnt <= 4'd0;
         r_shift   <= 9'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_dat_oe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_error   <= w_error_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_dat_oe  <= w_dat_oe_nxt;
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
   logic       ps2_clk_i, ps2_dat_i;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   // Wired-AND open-collector bus: either side can pull a line low.
   assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

   always #125 clk = ~clk;   // 4 MHz

   ps2_host_tx dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame as the device sees it, index 0 first: start, d0..d7, parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   logic [10:0] seen;
   logic        got_done, got_err, busy_at_done, clk_oe_at_done, dat_oe_at_done, done_after;
   int          inh_len, dat_at, silent_cycles;

   // mode 0 normal, 1 extra tx_start while busy, 2 reset after fall 5, 3 silent device
   task automatic run_xfer(input logic [7:0] b, input logic nack, input int half, input int mode);
      int n;
      bit aborted;
      aborted = 1'b0;
      seen = '0; got_done = 1'b0; got_err = 1'b0; busy_at_done = 1'b1;
      clk_oe_at_done = 1'b1; dat_oe_at_done = 1'b1; done_after = 1'b1;
      dat_at = -1;
      @(negedge clk); tx_data = b; tx_start = 1'b1;
      @(negedge clk); tx_start = 1'b0; tx_data = 8'h00;
      n = 0;
      while (ps2_clk_oe && n < 2000) begin
         n++;
         if (ps2_dat_oe && dat_at < 0) dat_at = n;
         @(negedge clk);
      end
      inh_len = n;
      seen[0] = ps2_dat_i;
      if (mode == 3) begin
         n = 0;
         while (!done && n < 70000) begin
            @(negedge clk);
            n++;
         end
         silent_cycles = n;
      end else begin
         repeat ($urandom_range(20, 80)) @(negedge clk);
         for (int k = 1; k <= 11 && !aborted; k++) begin
            dev_clk = 1'b0;
            if (k == 5 && mode == 2) begin
               repeat (12) @(negedge clk);
               reset = 1'b1;
               @(negedge clk);
               chk("reset_clk_oe", ps2_clk_oe, 0);
               chk("reset_dat_oe", ps2_dat_oe, 0);
               chk("reset_busy", busy, 0);
               chk("reset_done", done, 0);
               reset = 1'b0;
               dev_clk = 1'b1;
               dev_dat = 1'b1;
               aborted = 1'b1;
            end else if (k == 5 && mode == 1) begin
               repeat (2) @(negedge clk);
               chk("busy_mid", busy, 1);
               tx_data = ~b; tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0; tx_data = 8'h00;
               repeat (half - 3) @(negedge clk);
            end else begin
               repeat (half) @(negedge clk);
            end
            if (!aborted) begin
               dev_clk = 1'b1;
               if (k <= 10) seen[k] = ps2_dat_i;
               if (k == 10) dev_dat = nack;
               if (k == 11) dev_dat = 1'b1;
               if (k < 11) repeat (half) @(negedge clk);
            end
         end
         if (!aborted) begin
            n = 0;
            while (!done && n < 500) begin
               @(negedge clk);
               n++;
            end
         end
      end
      if (!aborted) begin
         got_done       = done;
         got_err        = error;
         busy_at_done   = busy;
         clk_oe_at_done = ps2_clk_oe;
         dat_oe_at_done = ps2_dat_oe;
         @(negedge clk);
         done_after     = done;
      end
   endtask

   typedef struct {
      logic [7:0]  data;
      logic        nack;
      int          half;
      logic [10:0] exp_frame;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];

   task automatic check_normal(input string tag, input logic [10:0] exp_frame, input logic exp_err);
      chk({tag, "_inhibit_len"}, inh_len, 480);
      chk({tag, "_dat_oe_rise"}, dat_at, 480);
      chk({tag, "_frame"}, seen, exp_frame);
      chk({tag, "_done"}, got_done, 1);
      chk({tag, "_error"}, got_err, exp_err);
      chk({tag, "_busy_at_done"}, busy_at_done, 0);
      chk({tag, "_single_done"}, done_after, 0);
      repeat (20) @(negedge clk);
      chk({tag, "_error_held"}, error, exp_err);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rn;
      int         d0;

      vecs[0] = '{8'hF4, 1'b0, 160, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 25,  {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1};
      vecs[2] = '{8'h00, 1'b0, 25,  {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0};
      vecs[3] = '{8'hA5, 1'b0, 30,  {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0};
      vecs[4] = '{8'h01, 1'b0, 40,  {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0};

      repeat (5) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_xfer(vecs[i].data, vecs[i].nack, vecs[i].half, 0);
         check_normal($sformatf("vec%0d", i), vecs[i].exp_frame, vecs[i].exp_err);
      end

      for (int i = 0; i < 5; i++) begin
         rb = 8'($urandom);
         rn = ($urandom_range(0, 3) == 0);
         run_xfer(rb, rn, $urandom_range(20, 40), 0);
         check_normal($sformatf("rnd%0d", i), model_frame(rb), rn);
      end

      d0 = done_cnt;
      run_xfer(8'h3C, 1'b0, 30, 1);
      check_normal("busy_ignore", model_frame(8'h3C), 1'b0);
      repeat (1000) @(negedge clk);
      chk("busy_ignore_done_count", done_cnt - d0, 1);
      chk("busy_ignore_idle_clk_oe", ps2_clk_oe, 0);
      chk("busy_ignore_idle_busy", busy, 0);

      run_xfer(8'h55, 1'b0, 0, 3);
      chk("silent_inhibit_len", inh_len, 480);
      chk("silent_cycles", silent_cycles, 60000);
      chk("silent_done", got_done, 1);
      chk("silent_error", got_err, 1);
      chk("silent_clk_oe", clk_oe_at_done, 0);
      chk("silent_dat_oe", dat_oe_at_done, 0);
      chk("silent_busy", busy_at_done, 0);
      repeat (10) @(negedge clk);

      d0 = done_cnt;
      run_xfer(8'h96, 1'b0, 25, 2);
      repeat (200) @(negedge clk);
      chk("reset_no_done", done_cnt - d0, 0);
      run_xfer(8'hF4, 1'b0, 25, 0);
      check_normal("after_reset", model_frame(8'hF4), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #30000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
